// File: rtl/ervp_jtag_word_link_pkg.sv
// Shared TAP definitions: state encodings, instruction codes and USERDATA bit layout.
package ervp_jtag_word_link_pkg;

    localparam int BW_TAP_STATE = 4;

    typedef enum logic [BW_TAP_STATE-1:0] {
        TAP_EX2_DR = 4'h0,
        TAP_EX1_DR = 4'h1,
        TAP_SH_DR  = 4'h2,
        TAP_PAU_DR = 4'h3,
        TAP_SEL_IR = 4'h4,
        TAP_UPD_DR = 4'h5,
        TAP_CAP_DR = 4'h6,
        TAP_SEL_DR = 4'h7,
        TAP_EX2_IR = 4'h8,
        TAP_EX1_IR = 4'h9,
        TAP_SH_IR  = 4'hA,
        TAP_PAU_IR = 4'hB,
        TAP_RTI    = 4'hC,
        TAP_UPD_IR = 4'hD,
        TAP_CAP_IR = 4'hE,
        TAP_TLR    = 4'hF
    } tap_state_t;

    localparam int BW_IR     = 4;
    localparam int BW_IDCODE = 32;

    localparam logic [BW_IR-1:0] IR_IDCODE   = 4'h1;
    localparam logic [BW_IR-1:0] IR_USERDATA = 4'h8;
    localparam logic [BW_IR-1:0] IR_BYPASS   = 4'hF;
    localparam logic [BW_IR-1:0] IR_CAPTURE  = 4'b0001;

    // USERDATA status/flag bits sit directly above the BW_DATA payload.
    localparam int UD_PUSH_OFS      = 0;
    localparam int UD_RX_STATUS_OFS = 1;

    function automatic logic is_ir_state(input tap_state_t s);
        return (s == TAP_CAP_IR) || (s == TAP_SH_IR)  || (s == TAP_EX1_IR) ||
               (s == TAP_PAU_IR) || (s == TAP_EX2_IR) || (s == TAP_UPD_IR);
    endfunction

endpackage

// File: rtl/ervp_jtag_word_link_tap_fsm.sv
// IEEE 1149.1 TAP controller advanced by the synchronized tck rise strobe.
module ervp_jtag_word_link_tap_fsm
    import ervp_jtag_word_link_pkg::*;
(
    input  logic       clk,
    input  logic       rstp,
    input  logic       rise,
    input  logic       tms,
    output tap_state_t state,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir,
    output logic       test_logic_reset
);

    tap_state_t state_next;

    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            state <= TAP_TLR;
        end else if (rise) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            TAP_TLR:    state_next = tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:    state_next = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR: state_next = tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR: state_next = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:  state_next = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR: state_next = tms ? TAP_UPD_DR : TAP_PAU_DR;
            TAP_PAU_DR: state_next = tms ? TAP_EX2_DR : TAP_PAU_DR;
            TAP_EX2_DR: state_next = tms ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR: state_next = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR: state_next = tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR: state_next = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:  state_next = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR: state_next = tms ? TAP_UPD_IR : TAP_PAU_IR;
            TAP_PAU_IR: state_next = tms ? TAP_EX2_IR : TAP_PAU_IR;
            TAP_EX2_IR: state_next = tms ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR: state_next = tms ? TAP_SEL_DR : TAP_RTI;
            default:    state_next = TAP_TLR;
        endcase
    end

    // Actions fire on the rise that leaves the corresponding state.
    always_comb begin
        capture_dr       = rise && (state == TAP_CAP_DR);
        shift_dr         = rise && (state == TAP_SH_DR);
        update_dr        = rise && (state == TAP_UPD_DR);
        capture_ir       = rise && (state == TAP_CAP_IR);
        shift_ir         = rise && (state == TAP_SH_IR);
        update_ir        = rise && (state == TAP_UPD_IR);
        test_logic_reset = (state == TAP_TLR);
    end

endmodule

// File: rtl/ervp_jtag_word_link.sv
// JTAG pin sampler, TAP, IR/DR shift chains and rx/tx word holding registers.
module ervp_jtag_word_link
    import ervp_jtag_word_link_pkg::*;
#(
    parameter int                   BW_DATA      = 32,
    parameter logic [BW_IDCODE-1:0] IDCODE_VALUE = 32'h1000_0E7D,
    parameter int                   NUM_SYNC     = 2
) (
    input  logic               clk,
    input  logic               rstp,
    input  logic               jtag_tck,
    input  logic               jtag_tms,
    input  logic               jtag_tdi,
    output logic               jtag_tdo,
    output logic               jtag_tdo_en,
    output logic               rx_valid,
    output logic [BW_DATA-1:0] rx_data,
    input  logic               rx_ready,
    input  logic               tx_valid,
    input  logic [BW_DATA-1:0] tx_data,
    output logic               tx_ready
);

    localparam int BW_USER   = BW_DATA + 2;
    localparam int PUSH_BIT  = BW_DATA + UD_PUSH_OFS;
    localparam int RXST_BIT  = BW_DATA + UD_RX_STATUS_OFS;

    logic [NUM_SYNC-1:0] tck_sync, tms_sync, tdi_sync;
    logic                tck_hist;
    logic                tck_s, tms_s, tdi_s, rise, fall;

    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            tck_sync <= '0;
            tms_sync <= '0;
            tdi_sync <= '0;
            tck_hist <= 1'b0;
        end else begin
            tck_sync <= {tck_sync[NUM_SYNC-2:0], jtag_tck};
            tms_sync <= {tms_sync[NUM_SYNC-2:0], jtag_tms};
            tdi_sync <= {tdi_sync[NUM_SYNC-2:0], jtag_tdi};
            tck_hist <= tck_sync[NUM_SYNC-1];
        end
    end

    assign tck_s = tck_sync[NUM_SYNC-1];
    assign tms_s = tms_sync[NUM_SYNC-1];
    assign tdi_s = tdi_sync[NUM_SYNC-1];
    assign rise  = tck_s & ~tck_hist;
    assign fall  = ~tck_s & tck_hist;

    tap_state_t state;
    logic capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir, tlr;

    ervp_jtag_word_link_tap_fsm u_tap (
        .clk              (clk),
        .rstp             (rstp),
        .rise             (rise),
        .tms              (tms_s),
        .state            (state),
        .capture_dr       (capture_dr),
        .shift_dr         (shift_dr),
        .update_dr        (update_dr),
        .capture_ir       (capture_ir),
        .shift_ir         (shift_ir),
        .update_ir        (update_ir),
        .test_logic_reset (tlr)
    );

    logic [BW_IR-1:0]     ir_reg, ir_sh;
    logic [BW_IDCODE-1:0] dr_idcode;
    logic                 dr_bypass;
    logic [BW_USER-1:0]   dr_user;
    logic                 sel_user, dr_lsb;

    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            ir_reg <= IR_IDCODE;
        end else if (tlr) begin
            ir_reg <= IR_IDCODE;
        end else if (update_ir) begin
            ir_reg <= ir_sh;
        end
    end

    assign sel_user = (ir_reg == IR_USERDATA);

    always_comb begin
        dr_lsb = dr_bypass;
        case (ir_reg)
            IR_IDCODE:   dr_lsb = dr_idcode[0];
            IR_USERDATA: dr_lsb = dr_user[0];
            IR_BYPASS:   dr_lsb = dr_bypass;
            default:     dr_lsb = dr_bypass;
        endcase
    end

    logic               rx_full, tx_full, dropped_sticky;
    logic [BW_DATA-1:0] rx_reg, tx_reg;
    logic               user_capture, user_push, rx_xfer, tx_xfer, push_ok;

    // All DR chains capture and shift together; only the selected one reaches TDO or updates.
    always_ff @(posedge clk) begin
        if (capture_dr) begin
            dr_idcode <= IDCODE_VALUE;
            dr_bypass <= 1'b0;
            dr_user   <= {rx_full | dropped_sticky, tx_full, tx_reg};
        end else if (shift_dr) begin
            dr_idcode <= {tdi_s, dr_idcode[BW_IDCODE-1:1]};
            dr_bypass <= tdi_s;
            dr_user   <= {tdi_s, dr_user[BW_USER-1:1]};
        end
        if (capture_ir) begin
            ir_sh <= IR_CAPTURE;
        end else if (shift_ir) begin
            ir_sh <= {tdi_s, ir_sh[BW_IR-1:1]};
        end
        if (tx_xfer) begin
            tx_reg <= tx_data;
        end
    end

    assign user_capture = capture_dr & sel_user;
    assign user_push    = update_dr & sel_user & dr_user[PUSH_BIT];
    assign rx_xfer      = rx_full & rx_ready;
    assign tx_xfer      = tx_valid & ~tx_full;
    // A consumer pop in the same cycle frees the slot for the incoming push.
    assign push_ok      = user_push & (~rx_full | rx_xfer);

    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            rx_full        <= 1'b0;
            tx_full        <= 1'b0;
            dropped_sticky <= 1'b0;
            rx_reg         <= '0;
            jtag_tdo       <= 1'b0;
            jtag_tdo_en    <= 1'b0;
        end else begin
            if (push_ok) begin
                rx_full <= 1'b1;
                rx_reg  <= dr_user[BW_DATA-1:0];
            end else if (rx_xfer) begin
                rx_full <= 1'b0;
            end
            if (tx_xfer) begin
                tx_full <= 1'b1;
            end else if (user_capture) begin
                tx_full <= 1'b0;
            end
            if (user_capture) begin
                dropped_sticky <= 1'b0;
            end
            if (user_push && !push_ok) begin
                dropped_sticky <= 1'b1;
            end
            if (fall) begin
                jtag_tdo    <= is_ir_state(state) ? ir_sh[0] : dr_lsb;
                jtag_tdo_en <= (state == TAP_SH_DR) || (state == TAP_SH_IR);
            end
        end
    end

    assign rx_valid = rx_full;
    assign rx_data  = rx_reg;
    assign tx_ready = ~tx_full;

    logic unused_rxst;
    assign unused_rxst = dr_user[RXST_BIT];

endmodule

// File: tb/tb_ervp_jtag_word_link.sv
// Directed bench: drives JTAG scans through the word link and scoreboards TDO streams and rx words.
module tb_ervp_jtag_word_link;

    localparam int          BW_DATA = 32;
    localparam logic [31:0] IDCODE  = 32'h1000_0E7D;
    localparam int          HALF    = 6;
    localparam logic [63:0] ST_MASK = 64'h3_0000_0000;

    logic               clk = 1'b0;
    logic               rstp = 1'b1;
    logic               jtag_tck = 1'b0;
    logic               jtag_tms = 1'b0;
    logic               jtag_tdi = 1'b0;
    logic               jtag_tdo, jtag_tdo_en;
    logic               rx_valid;
    logic [BW_DATA-1:0] rx_data;
    logic               rx_ready = 1'b0;
    logic               tx_valid = 1'b0;
    logic [BW_DATA-1:0] tx_data = '0;
    logic               tx_ready;

    int checks = 0;
    int failures = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    ervp_jtag_word_link #(.BW_DATA(BW_DATA), .IDCODE_VALUE(IDCODE), .NUM_SYNC(2)) dut (
        .clk         (clk),
        .rstp        (rstp),
        .jtag_tck    (jtag_tck),
        .jtag_tms    (jtag_tms),
        .jtag_tdi    (jtag_tdi),
        .jtag_tdo    (jtag_tdo),
        .jtag_tdo_en (jtag_tdo_en),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag, input logic [63:0] obs);
        logic [63:0] exp;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, obs);
        end else begin
            exp = sb_q.pop_front();
            check(tag, obs, exp);
        end
    endtask

    task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v);
        jtag_tms = tms_v;
        jtag_tdi = tdi_v;
        @(negedge clk);
        tdo_v = jtag_tdo;
        jtag_tck = 1'b1;
        repeat (HALF) @(negedge clk);
        jtag_tck = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic tms_step(input logic tms_v);
        logic d;
        tck_cycle(tms_v, 1'b0, d);
    endtask

    task automatic scan_dr(input logic [63:0] din, input int n, output logic [63:0] dout);
        logic b;
        dout = '0;
        tms_step(1'b1); tms_step(1'b0); tms_step(1'b0);
        for (int i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, din[i], b);
            dout[i] = b;
        end
        tms_step(1'b1); tms_step(1'b0);
    endtask

    task automatic scan_ir(input logic [3:0] code, output logic [63:0] dout);
        logic b;
        dout = '0;
        tms_step(1'b1); tms_step(1'b1); tms_step(1'b0); tms_step(1'b0);
        for (int i = 0; i < 4; i++) begin
            tck_cycle(i == 3, code[i], b);
            dout[i] = b;
        end
        tms_step(1'b1); tms_step(1'b0);
    endtask

    task automatic wait_rx(input string tag);
        int n;
        n = 0;
        while (!rx_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rx_valid) begin
            checks++;
            failures++;
            $error("FAIL %s observed=rx_valid low expected=rx_valid within 20 cycles", tag);
        end else begin
            check_pop(tag, 64'(rx_data));
        end
    endtask

    task automatic drain_rx();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    logic [63:0] out;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        rstp = 1'b0;
        @(negedge clk);
        check("reset_tdo", 64'(jtag_tdo), 64'd0);
        check("reset_tdo_en", 64'(jtag_tdo_en), 64'd0);
        check("reset_rx_valid", 64'(rx_valid), 64'd0);
        check("reset_rx_data", 64'(rx_data), 64'd0);
        check("reset_tx_ready", 64'(tx_ready), 64'd1);

        // IDCODE read after forcing TLR
        repeat (5) tms_step(1'b1);
        tms_step(1'b0);
        sb_q.push_back(64'(IDCODE));
        scan_dr(64'd0, 32, out);
        check_pop("idcode", out);
        check("idcode_rx_valid", 64'(rx_valid), 64'd0);
        check("idcode_tdo_en_off", 64'(jtag_tdo_en), 64'd0);

        // USERDATA push
        sb_q.push_back(64'b0001);
        scan_ir(4'h8, out);
        check_pop("ir_capture", out);
        sb_q.push_back(64'hDEAD_BEEF);
        scan_dr(64'h1_DEAD_BEEF, 34, out);
        check("push_status", out & ST_MASK, 64'd0);
        wait_rx("push_rx_data");
        repeat (3) @(negedge clk);
        check("push_rx_hold", 64'(rx_valid), 64'd1);
        drain_rx();
        check("push_rx_drain", 64'(rx_valid), 64'd0);

        // Response return
        tx_valid = 1'b1;
        tx_data  = 32'h0000_00A5;
        @(negedge clk);
        tx_valid = 1'b0;
        check("tx_ready_low", 64'(tx_ready), 64'd0);
        sb_q.push_back(64'h1_0000_00A5);
        scan_dr(64'd0, 34, out);
        check_pop("tx_capture", out);
        check("tx_ready_back", 64'(tx_ready), 64'd1);
        sb_q.push_back(64'h0_0000_00A5);
        scan_dr(64'd0, 34, out);
        check_pop("tx_second_scan", out);

        // Overflow: second push dropped, sticky reported once
        sb_q.push_back(64'h1111_1111);
        scan_dr(64'h1_1111_1111, 34, out);
        wait_rx("ovf_first_word");
        scan_dr(64'h1_2222_2222, 34, out);
        check("ovf_capture_full", out & ST_MASK, 64'h2_0000_0000);
        repeat (3) @(negedge clk);
        check("ovf_rx_keep", 64'(rx_data), 64'h1111_1111);
        drain_rx();
        check("ovf_drained", 64'(rx_valid), 64'd0);
        scan_dr(64'd0, 34, out);
        check("ovf_sticky_set", out & ST_MASK, 64'h2_0000_0000);
        scan_dr(64'd0, 34, out);
        check("ovf_sticky_clear", out & ST_MASK, 64'd0);

        // Illegal IR behaves as BYPASS
        scan_ir(4'h5, out);
        sb_q.push_back(64'h64);
        scan_dr(64'hB2, 8, out);
        check_pop("bypass_stream", out);
        check("bypass_rx_valid", 64'(rx_valid), 64'd0);

        // Asynchronous reset mid Shift-DR
        tx_valid = 1'b1;
        tx_data  = 32'h0000_005A;
        @(negedge clk);
        tx_valid = 1'b0;
        check("rst_tx_ready_low", 64'(tx_ready), 64'd0);
        scan_ir(4'h8, out);
        tms_step(1'b1); tms_step(1'b0); tms_step(1'b0);
        for (int i = 0; i < 10; i++) begin
            logic d;
            tck_cycle(1'b0, 1'b1, d);
        end
        check("rst_tdo_en_in_shift", 64'(jtag_tdo_en), 64'd1);
        #2 rstp = 1'b1;
        repeat (2) @(negedge clk);
        rstp = 1'b0;
        @(negedge clk);
        check("rst_tx_ready", 64'(tx_ready), 64'd1);
        check("rst_rx_valid", 64'(rx_valid), 64'd0);
        check("rst_tdo_en", 64'(jtag_tdo_en), 64'd0);
        tms_step(1'b0);
        sb_q.push_back(64'(IDCODE));
        scan_dr(64'd0, 32, out);
        check_pop("rst_idcode", out);
        check("rst_no_push", 64'(rx_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
